// File: rtl/sincos_lut_pipe_pkg.sv
// Shared constants, quadrant type and the elaboration-time cosine table generator
// for the sine/cosine LUT pipeline.
package sincos_lut_pipe_pkg;

  localparam logic [63:0] QNAN_64  = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] ONE_64   = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] ZERO_64  = 64'h0000_0000_0000_0000;
  localparam logic        MODE_COS = 1'b0;
  localparam logic        MODE_SIN = 1'b1;
  localparam real         PI       = 3.141592653589793;

  typedef enum logic [1:0] {QUAD0, QUAD1, QUAD2, QUAD3} quad_t;

  // Magnitude bits of cos(k*90/qsteps deg); only evaluated while building the ROM.
  // The end points are pinned so that 0 and 90 degrees come out exact.
  function automatic logic [62:0] cos_mag(input int k, input int qsteps);
    real         deg;
    logic [63:0] bits;
    logic [62:0] mag;
    if (k == 0) begin
      mag = ONE_64[62:0];
    end else if (k >= qsteps) begin
      mag = ZERO_64[62:0];
    end else begin
      deg  = real'(k) * 90.0 / real'(qsteps);
      bits = $realtobits($cos(deg * PI / 180.0));
      mag  = bits[62:0];
    end
    return mag;
  endfunction

endpackage

// File: rtl/sincos_quarter_rom.sv
// Quarter-wave cosine magnitude ROM, QSTEPS+1 entries, synchronous read with enable.
module sincos_quarter_rom
  import sincos_lut_pipe_pkg::*;
#(
  parameter int QSTEPS = 90,
  parameter int AW     = $clog2(QSTEPS + 1)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  output logic [62:0]   data
);

  localparam logic [AW-1:0] LAST = AW'(QSTEPS);

  logic [62:0] rom_tab [QSTEPS+1];

  for (genvar k = 0; k <= QSTEPS; k++) begin : g_entry
    localparam logic [62:0] ENTRY = cos_mag(k, QSTEPS);
    assign rom_tab[k] = ENTRY;
  end

  // Addresses past the table only occur for out-of-range angles, whose value is discarded.
  always_ff @(posedge clk) begin
    if (en) begin
      data <= (addr <= LAST) ? rom_tab[addr] : '0;
    end
  end

endmodule

// File: rtl/sincos_lut_pipe.sv
// Pipelined sine/cosine unit: full-circle angle in, IEEE-754 double out.
// S1 reduces to quadrant/remainder, S2 folds and reads the ROM, S3 applies sign or NaN.
module sincos_lut_pipe
  import sincos_lut_pipe_pkg::*;
#(
  parameter int QSTEPS  = 90,
  parameter int ANGLE_W = 9,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ANGLE_W-1:0] in_angle,
  input  logic               in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [63:0]        out_data,
  output logic               out_err,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int RW  = $clog2(QSTEPS + 1);
  localparam int AXW = ANGLE_W + 1;
  localparam logic [AXW-1:0] LIM1 = AXW'(QSTEPS);
  localparam logic [AXW-1:0] LIM2 = AXW'(2 * QSTEPS);
  localparam logic [AXW-1:0] LIM3 = AXW'(3 * QSTEPS);
  localparam logic [AXW-1:0] LIM4 = AXW'(4 * QSTEPS);
  localparam logic [RW-1:0]  QR   = RW'(QSTEPS);

  logic              s1_adv, s2_adv, s3_adv;
  logic              s1_valid, s2_valid;
  logic              s1_err, s1_mode;
  quad_t             s1_q;
  logic [RW-1:0]     s1_r;
  logic [TAG_W-1:0]  s1_tag;
  logic              s2_err, s2_neg;
  logic [TAG_W-1:0]  s2_tag;
  logic [62:0]       s2_mag;

  logic [AXW-1:0]    ang_x, base;
  quad_t             q_c;
  logic [RW-1:0]     r_c;
  logic              err_c;
  logic              fold_hi, neg_c;
  logic [RW-1:0]     rom_addr;

  assign s3_adv   = !out_valid || out_ready;
  assign s2_adv   = !s2_valid || s3_adv;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Widened by one bit so LIM4 never wraps when 2**ANGLE_W == 4*QSTEPS.
  always_comb begin
    ang_x = {1'b0, in_angle};
    q_c   = QUAD0;
    base  = '0;
    if (ang_x >= LIM3) begin
      q_c  = QUAD3;
      base = LIM3;
    end else if (ang_x >= LIM2) begin
      q_c  = QUAD2;
      base = LIM2;
    end else if (ang_x >= LIM1) begin
      q_c  = QUAD1;
      base = LIM1;
    end
  end

  assign err_c = (ang_x >= LIM4);
  assign r_c   = RW'(ang_x - base);

  // Sine is cosine shifted a quarter turn, so the fold direction flips with the mode.
  assign fold_hi  = s1_q[0] ^ (s1_mode == MODE_SIN);
  assign rom_addr = fold_hi ? (QR - s1_r) : s1_r;
  assign neg_c    = (s1_mode == MODE_SIN) ? s1_q[1] : (s1_q[1] ^ s1_q[0]);

  sincos_quarter_rom #(
    .QSTEPS (QSTEPS),
    .AW     (RW)
  ) u_rom (
    .clk  (clk),
    .en   (s2_adv),
    .addr (rom_addr),
    .data (s2_mag)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= ZERO_64;
      out_err   <= 1'b0;
      out_tag   <= '0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (s2_adv) s2_valid <= s1_valid;
      if (s3_adv) begin
        out_valid <= s2_valid;
        if (s2_valid) begin
          out_data <= s2_err ? QNAN_64 : {s2_neg && (|s2_mag), s2_mag};
          out_err  <= s2_err;
          out_tag  <= s2_tag;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_err  <= err_c;
      s1_q    <= q_c;
      s1_r    <= r_c;
      s1_mode <= in_mode;
      s1_tag  <= in_tag;
    end
    if (s2_adv && s1_valid) begin
      s2_err <= s1_err;
      s2_neg <= neg_c;
      s2_tag <= s1_tag;
    end
  end

endmodule

// File: tb/tb_sincos_lut_pipe.sv
// Scoreboard bench for sincos_lut_pipe: driver queues expected results, monitor pops on output handshakes.
module tb_sincos_lut_pipe;

  localparam int QS = 90;
  localparam int AW = 9;
  localparam int TW = 4;
  localparam logic [63:0] ONE  = 64'h3FF0000000000000;
  localparam logic [63:0] MONE = 64'hBFF0000000000000;
  localparam logic [63:0] HALF = 64'h3FE0000000000001;
  localparam logic [63:0] MHLF = 64'hBFE0000000000001;
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;

  typedef struct {
    logic [63:0]   data;
    logic          err;
    logic [TW-1:0] tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_angle = '0;
  logic          in_mode = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [63:0]   out_data;
  logic          out_err;
  logic [TW-1:0] out_tag;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            acc_cnt = 0;
  int            out_cnt = 0;
  int            rdy_mode = 0;
  bit            mon_en = 1'b0;
  bit            held = 1'b0;
  exp_t          held_v;

  always #5 clk = ~clk;

  sincos_lut_pipe #(.QSTEPS(QS), .ANGLE_W(AW), .TAG_W(TW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_angle  (in_angle),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_tag   (out_tag)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Golden model written from the angle arithmetic directly (divide/modulo reduction).
  function automatic logic [63:0] model(input int ang, input bit sin_m);
    int          q, r, idx;
    bit          neg;
    logic [63:0] bits;
    if (ang >= 4 * QS) return QNAN;
    q = ang / QS;
    r = ang % QS;
    if (sin_m) begin
      idx = (q % 2 == 1) ? r : QS - r;
      neg = (q >= 2);
    end else begin
      idx = (q % 2 == 1) ? QS - r : r;
      neg = (q == 1) || (q == 2);
    end
    if (idx == QS) return 64'h0;
    bits = $realtobits($cos(real'(idx) * 90.0 / real'(QS) * 3.141592653589793 / 180.0));
    bits[63] = neg;
    return bits;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send(input int ang, input bit mode, input int tag, input logic [63:0] ed, input bit ee);
    exp_t e;
    int   waitc;
    waitc    = 0;
    in_valid = 1'b1;
    in_angle = AW'(ang);
    in_mode  = mode;
    in_tag   = TW'(tag);
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waitc++;
      if (waitc > 1000) break;
    end
    if (waitc > 1000) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: angle %0d never accepted", ang);
    end else begin
      e.data = ed;
      e.err  = ee;
      e.tag  = TW'(tag);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic lat_check(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    chk(name, 64'(n), 64'd3);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: in_ready rule, hold stability under backpressure, and in-order scoreboard.
  initial begin
    int   occ;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        occ = acc_cnt - out_cnt;
        chk("in_ready_rule", 64'(in_ready), 64'(!(occ == 3 && !out_ready)));
        if (in_valid && in_ready) acc_cnt++;
        if (out_valid) begin
          if (held) begin
            chk("hold_data", out_data, held_v.data);
            chk("hold_err", 64'(out_err), 64'(held_v.err));
            chk("hold_tag", 64'(out_tag), 64'(held_v.tag));
          end
          if (out_ready) begin
            out_cnt++;
            held = 1'b0;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_output: data %h tag %0d with nothing pending", out_data, out_tag);
            end else begin
              e = exp_q.pop_front();
              chk("out_data", out_data, e.data);
              chk("out_err", 64'(out_err), 64'(e.err));
              chk("out_tag", 64'(out_tag), 64'(e.tag));
            end
          end else begin
            held        = 1'b1;
            held_v.data = out_data;
            held_v.err  = out_err;
            held_v.tag  = out_tag;
          end
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    send(0, 1'b0, 1, ONE, 1'b0);
    lat_check("latency_first");
    wait_drain();

    send(30,  1'b1, 2,  HALF, 1'b0);
    send(120, 1'b0, 3,  MHLF, 1'b0);
    send(180, 1'b1, 4,  64'h0, 1'b0);
    send(270, 1'b0, 7,  64'h0, 1'b0);
    send(360, 1'b0, 5,  QNAN, 1'b1);
    send(0,   1'b0, 6,  ONE, 1'b0);
    send(90,  1'b0, 8,  64'h0, 1'b0);
    send(180, 1'b0, 9,  MONE, 1'b0);
    send(90,  1'b1, 10, ONE, 1'b0);
    send(270, 1'b1, 11, MONE, 1'b0);
    send(60,  1'b0, 12, HALF, 1'b0);
    send(511, 1'b1, 13, QNAN, 1'b1);
    wait_drain();

    rdy_mode = 2;
    for (int a = 0; a < 4 * QS; a++) begin
      for (int m = 0; m < 2; m++) begin
        send(a, 1'(m), a + m, model(a, 1'(m)), 1'b0);
      end
    end
    wait_drain();

    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    send(10, 1'b0, 1, model(10, 1'b0), 1'b0);
    send(20, 1'b1, 2, model(20, 1'b1), 1'b0);
    send(30, 1'b0, 3, model(30, 1'b0), 1'b0);
    repeat (4) @(posedge clk);
    #1;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    acc_cnt = 0;
    out_cnt = 0;
    held    = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    rdy_mode = 0;
    mon_en   = 1'b1;
    @(posedge clk);
    #1;
    send(120, 1'b0, 14, MHLF, 1'b0);
    lat_check("latency_after_reset");
    wait_drain();
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
